seg7_bank: RTL and testbench

Parametrised multi-digit seven-segment driver for the board display path. Accepts a binary value with a load strobe and converts it to decimal with a sequential double-dabble engine, or splits it into hex nibbles. It then encodes every digit to active-low segment patterns and holds them in registers until the next load. It is the generalised successor of the fixed five-digit BCD display block, and replaces per-digit BCD splitting in the datapath top level.

---
 rtl/seg7_pkg.sv | 54 +++++
 rtl/seg7_if.sv | 26 ++
 rtl/seg7_dabble.sv | 63 ++++++
 rtl/seg7_bank.sv | 105 ++++++++++
 tb/tb_seg7_bank.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/seg7_pkg.sv
// seg7_bank shared types: segment constants, FSM states and digit encoder.
// Build option SEG7_LZB_EN (leading-zero blanking) is consumed by seg7_bank.
package seg7_pkg;

   localparam logic [6:0] SEG_0     = 7'b1000000;
   localparam logic [6:0] SEG_1     = 7'b1111001;
   localparam logic [6:0] SEG_2     = 7'b0100100;
   localparam logic [6:0] SEG_3     = 7'b0110000;
   localparam logic [6:0] SEG_4     = 7'b0011001;
   localparam logic [6:0] SEG_5     = 7'b0010010;
   localparam logic [6:0] SEG_6     = 7'b0000010;
   localparam logic [6:0] SEG_7     = 7'b1111000;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0010000;
   localparam logic [6:0] SEG_A     = 7'b0001000;
   localparam logic [6:0] SEG_B     = 7'b0000011;
   localparam logic [6:0] SEG_C     = 7'b1000110;
   localparam logic [6:0] SEG_D     = 7'b0100001;
   localparam logic [6:0] SEG_E     = 7'b0000110;
   localparam logic [6:0] SEG_F     = 7'b0001110;
   localparam logic [6:0] SEG_DASH  = 7'b0111111;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      ENCODE
   } state_t;

   function automatic logic [6:0] seg_of(input logic [3:0] d);
      logic [6:0] s;
      s = SEG_BLANK;
      unique case (d)
         4'h0: s = SEG_0;
         4'h1: s = SEG_1;
         4'h2: s = SEG_2;
         4'h3: s = SEG_3;
         4'h4: s = SEG_4;
         4'h5: s = SEG_5;
         4'h6: s = SEG_6;
         4'h7: s = SEG_7;
         4'h8: s = SEG_8;
         4'h9: s = SEG_9;
         4'hA: s = SEG_A;
         4'hB: s = SEG_B;
         4'hC: s = SEG_C;
         4'hD: s = SEG_D;
         4'hE: s = SEG_E;
         4'hF: s = SEG_F;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/seg7_if.sv
// seg7_bank request/result bundle; master drives the load side.
// Widths follow the NUM_DIGITS/BIN_W of the attached seg7_bank.
interface seg7_if #(
   parameter int NUM_DIGITS = 5,
   parameter int BIN_W      = 16
) ();

   logic [BIN_W-1:0]        value;
   logic                    load;
   logic                    hex_mode;
   logic [7*NUM_DIGITS-1:0] seg;
   logic                    busy;
   logic                    done;
   logic                    overflow;

   modport master (
      output value, load, hex_mode,
      input  seg, busy, done, overflow
   );

   modport slave (
      input  value, load, hex_mode,
      output seg, busy, done, overflow
   );

endinterface

// File: rtl/seg7_dabble.sv
// Sequential double-dabble engine; also preloads hex nibbles directly.
// ovf is sticky over one conversion and cleared by start.
module seg7_dabble #(
   parameter int NUM_DIGITS = 5,
   parameter int BIN_W      = 16
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    start,
   input  logic                    hex,
   input  logic                    step,
   input  logic [BIN_W-1:0]        value,
   output logic [4*NUM_DIGITS-1:0] bcd,
   output logic                    ovf,
   output logic                    last
);

   localparam int BW = 4 * NUM_DIGITS;
   localparam int WW = (BIN_W > BW) ? BIN_W : BW;
   localparam int CW = $clog2(BIN_W + 1);

   logic [BIN_W-1:0] sr;
   logic [CW-1:0]    cnt;
   logic [BW-1:0]    adj;
   logic [WW-1:0]    vext;

   assign vext = WW'(value);
   assign last = (cnt == CW'(1));

   always_comb begin
      adj = bcd;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (bcd[4*i +: 4] >= 4'd5)
            adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
      end
   end

   // the bit leaving the top digit is a value that needs one more digit
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sr  <= '0;
         bcd <= '0;
         cnt <= '0;
         ovf <= 1'b0;
      end else if (start) begin
         cnt <= CW'(BIN_W);
         if (hex) begin
            bcd <= vext[BW-1:0];
            sr  <= '0;
            ovf <= ((vext >> BW) != '0);
         end else begin
            bcd <= '0;
            sr  <= value;
            ovf <= 1'b0;
         end
      end else if (step) begin
         {bcd, sr} <= {adj[BW-2:0], sr, 1'b0};
         ovf       <= ovf | adj[BW-1];
         cnt       <= cnt - CW'(1);
      end
   end

endmodule

// File: rtl/seg7_bank.sv
// Multi-digit seven-segment driver: binary to decimal/hex, active-low out.
// Define SEG7_LZB_EN to blank leading zero digits.
import seg7_pkg::*;

module seg7_bank #(
   parameter int NUM_DIGITS = 5,
   parameter int BIN_W      = 16
) (
   input  logic  clk,
   input  logic  rst_n,
   seg7_if.slave bus
);

   state_t st, st_nx;

   logic                    start;
   logic                    step;
   logic                    enc;
   logic [4*NUM_DIGITS-1:0] bcd;
   logic                    ovf;
   logic                    last;
   logic [7*NUM_DIGITS-1:0] seg_nx;

   seg7_dabble #(
      .NUM_DIGITS(NUM_DIGITS),
      .BIN_W     (BIN_W)
   ) u_dabble (
      .clk  (clk),
      .rst_n(rst_n),
      .start(start),
      .hex  (bus.hex_mode),
      .step (step),
      .value(bus.value),
      .bcd  (bcd),
      .ovf  (ovf),
      .last (last)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) st <= IDLE;
      else        st <= st_nx;
   end

   always_comb begin
      st_nx = st;
      unique case (st)
         IDLE:    if (bus.load) st_nx = bus.hex_mode ? ENCODE : SHIFT;
         SHIFT:   if (last) st_nx = ENCODE;
         ENCODE:  st_nx = IDLE;
         default: st_nx = IDLE;
      endcase
   end

   always_comb begin
      start    = 1'b0;
      step     = 1'b0;
      enc      = 1'b0;
      bus.busy = 1'b1;
      unique case (1'b1)
         (st == SHIFT):  step = 1'b1;
         (st == ENCODE): enc  = 1'b1;
         default: begin
            bus.busy = 1'b0;
            start    = bus.load;
         end
      endcase
   end

   always_comb begin
      logic [3:0] d;
`ifdef SEG7_LZB_EN
      logic lead;
      lead = 1'b1;
`endif
      d      = '0;
      seg_nx = '1;
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         d = bcd[4*i +: 4];
`ifdef SEG7_LZB_EN
         // digit 0 is never blanked so zero reads as "0"
         lead = lead && (d == 4'd0) && (i != 0);
         if (ovf)       seg_nx[7*i +: 7] = SEG_DASH;
         else if (lead) seg_nx[7*i +: 7] = SEG_BLANK;
         else           seg_nx[7*i +: 7] = seg_of(d);
`else
         seg_nx[7*i +: 7] = ovf ? SEG_DASH : seg_of(d);
`endif
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.seg      <= '1;
         bus.overflow <= 1'b0;
         bus.done     <= 1'b0;
      end else begin
         bus.done <= enc;
         if (enc) begin
            bus.seg      <= seg_nx;
            bus.overflow <= ovf;
         end
      end
   end

endmodule

// File: tb/tb_seg7_bank.sv
// seg7_bank bench: 5-digit and 4-digit instances fed the same stimulus.
// Expected displays come from decimal/hex arithmetic, not the RTL.
module tb_seg7_bank;

`ifdef SEG7_LZB_EN
   localparam bit LZB = 1'b1;
`else
   localparam bit LZB = 1'b0;
`endif

   localparam logic [6:0] TBL [16] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
      7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
      7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
      7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
   };

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] value = '0;
   logic        load = 1'b0;
   logic        hex_mode = 1'b0;

   int ncmp = 0;
   int nerr = 0;

   seg7_if #(.NUM_DIGITS(5), .BIN_W(16)) ia ();
   seg7_if #(.NUM_DIGITS(4), .BIN_W(16)) ib ();

   assign ia.value    = value;
   assign ia.load     = load;
   assign ia.hex_mode = hex_mode;
   assign ib.value    = value;
   assign ib.load     = load;
   assign ib.hex_mode = hex_mode;

   seg7_bank #(.NUM_DIGITS(5), .BIN_W(16)) ua (
      .clk(clk), .rst_n(rst_n), .bus(ia)
   );
   seg7_bank #(.NUM_DIGITS(4), .BIN_W(16)) ub (
      .clk(clk), .rst_n(rst_n), .bus(ib)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      ncmp++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic logic [55:0] mdl(input int nd, input int unsigned v,
                                       input bit hx, output bit ov);
      longint unsigned b, p, lim, q;
      logic [55:0] s;
      b = hx ? 64'd16 : 64'd10;
      lim = 1;
      for (int i = 0; i < nd; i++) lim = lim * b;
      ov = (64'(v) >= lim);
      s = '1;
      p = 1;
      for (int i = 0; i < nd; i++) begin
         q = 64'(v) / p;
         if (ov)                       s[7*i +: 7] = 7'b0111111;
         else if (LZB && i > 0 && q == 0) s[7*i +: 7] = 7'b1111111;
         else                          s[7*i +: 7] = TBL[int'(q % b)];
         p = p * b;
      end
      return s;
   endfunction

   task automatic check_result(input string nm, input logic [15:0] v,
                               input bit hx);
      logic [55:0] ea, eb;
      bit oa, ob;
      ea = mdl(5, 32'(v), hx, oa);
      eb = mdl(4, 32'(v), hx, ob);
      chk({nm, " seg_a"}, 64'(ia.seg), 64'(ea[34:0]));
      chk({nm, " ovf_a"}, 64'(ia.overflow), 64'(oa));
      chk({nm, " seg_b"}, 64'(ib.seg), 64'(eb[27:0]));
      chk({nm, " ovf_b"}, 64'(ib.overflow), 64'(ob));
   endtask

   // starts at a negedge; returns at the negedge where done is seen
   task automatic run(input string nm, input logic [15:0] v, input bit hx,
                      output int lat);
      value = v; hex_mode = hx; load = 1'b1;
      @(negedge clk);
      load = 1'b0;
      value = 16'($urandom);
      hex_mode = 1'($urandom);
      chk({nm, " busy_acc"}, 64'(ia.busy), 64'(1));
      chk({nm, " done_acc"}, 64'(ia.done), 64'(0));
      lat = 0;
      while (!ia.done && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      chk({nm, " latency"}, 64'(lat), hx ? 64'(1) : 64'(17));
      chk({nm, " done_b"}, 64'(ib.done), 64'(1));
      chk({nm, " busy_end"}, 64'(ia.busy), 64'(0));
      check_result(nm, v, hx);
   endtask

   typedef struct {
      logic [15:0] v;
      bit          hx;
      int          lat;
      bit          ova;
      bit          ovb;
      logic [6:0]  d0;
   } vec_t;

   initial begin
      vec_t vt [9];
      int lat, cnt;
      logic [15:0] rv;
      bit rh;
      logic [34:0] sa;
      logic [27:0] sb;

      vt[0] = '{16'd12345,  1'b0, 17, 1'b0, 1'b1, 7'b0010010};
      vt[1] = '{16'h0BEF,   1'b1,  1, 1'b0, 1'b0, 7'b0001110};
      vt[2] = '{16'd0,      1'b0, 17, 1'b0, 1'b0, 7'b1000000};
      vt[3] = '{16'd999,    1'b0, 17, 1'b0, 1'b0, 7'b0010000};
      vt[4] = '{16'd65535,  1'b0, 17, 1'b0, 1'b1, 7'b0010010};
      vt[5] = '{16'd9999,   1'b0, 17, 1'b0, 1'b0, 7'b0010000};
      vt[6] = '{16'd10000,  1'b0, 17, 1'b0, 1'b1, 7'b1000000};
      vt[7] = '{16'hFFFF,   1'b1,  1, 1'b0, 1'b0, 7'b0001110};
      vt[8] = '{16'hA5C3,   1'b1,  1, 1'b0, 1'b0, 7'b0110000};

      repeat (3) @(negedge clk);
      chk("rst seg_a", 64'(ia.seg), 64'({35{1'b1}}));
      chk("rst busy", 64'(ia.busy), 64'(0));
      chk("rst done", 64'(ia.done), 64'(0));
      chk("rst ovf", 64'(ia.overflow), 64'(0));
      rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 9; i++) begin
         run($sformatf("vec%0d", i), vt[i].v, vt[i].hx, lat);
         chk($sformatf("vec%0d tlat", i), 64'(lat), 64'(vt[i].lat));
         chk($sformatf("vec%0d tova", i), 64'(ia.overflow), 64'(vt[i].ova));
         chk($sformatf("vec%0d tovb", i), 64'(ib.overflow), 64'(vt[i].ovb));
         chk($sformatf("vec%0d td0", i), 64'(ia.seg[6:0]), 64'(vt[i].d0));
         if (i == 0) begin
            sa = {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001, 7'b0010010};
            sb = {4{7'b0111111}};
            chk("12345 full_a", 64'(ia.seg), 64'(sa));
            chk("12345 dash_b", 64'(ib.seg), 64'(sb));
         end
      end

      // load during conversion must be dropped
      value = 16'd12345; hex_mode = 1'b0; load = 1'b1;
      @(negedge clk);
      load = 1'b0;
      repeat (4) @(negedge clk);
      value = 16'h0777; hex_mode = 1'b1; load = 1'b1;
      @(negedge clk);
      load = 1'b0;
      chk("ign busy", 64'(ia.busy), 64'(1));
      lat = 5;
      while (!ia.done && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      chk("ign latency", 64'(lat), 64'(17));
      check_result("ign", 16'd12345, 1'b0);
      cnt = 0;
      repeat (25) begin
         @(negedge clk);
         if (ia.done) cnt++;
      end
      chk("ign extra_done", 64'(cnt), 64'(0));

      // reset in the middle of a conversion
      value = 16'd4321; hex_mode = 1'b0; load = 1'b1;
      @(negedge clk);
      load = 1'b0;
      repeat (7) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("abort seg_a", 64'(ia.seg), 64'({35{1'b1}}));
      chk("abort seg_b", 64'(ib.seg), 64'({28{1'b1}}));
      chk("abort busy", 64'(ia.busy), 64'(0));
      chk("abort done", 64'(ia.done), 64'(0));
      chk("abort ovf", 64'(ia.overflow), 64'(0));
      @(negedge clk);
      rst_n = 1'b1;
      cnt = 0;
      repeat (20) begin
         @(negedge clk);
         if (ia.done || ia.busy) cnt++;
      end
      chk("abort quiet", 64'(cnt), 64'(0));
      run("after_abort", 16'd999, 1'b0, lat);

      for (int i = 0; i < 40; i++) begin
         rv = 16'($urandom);
         if ($urandom_range(0, 3) == 0) rv = 16'($urandom_range(0, 120));
         rh = 1'($urandom);
         run($sformatf("rnd%0d", i), rv, rh, lat);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
      $finish;
   end

endmodule
